// File: rtl/mult_rs.sv
// mult_rs: multiply-unit reservation station; compacting queue, oldest-ready-first issue.
// Optional feature macro MULT_RS_WAKEUP_BYPASS_EN: same-cycle CDB wakeup makes an entry issuable.
package mult_rs_pkg;
    localparam int XLEN          = 32;
    localparam int EBR_MASK_SIZE = 4;
    localparam int ROB_BITS      = 5;
    localparam int PREG_W        = 6;

    typedef struct packed {
        logic                     valid;
        logic [31:0]              inst;
        logic [ROB_BITS-1:0]      rob_id;
        logic [PREG_W-1:0]        prd_s;
        logic [4:0]               lrd_s;
        logic [XLEN-1:0]          pc;
        logic [XLEN-1:0]          prs1_v;
        logic [XLEN-1:0]          prs2_v;
        logic [EBR_MASK_SIZE-1:0] ebr_mask;
    } eu_operand_t;

    typedef struct packed {
        logic [PREG_W-1:0] prd_s;
        logic [XLEN-1:0]   prd_v;
    } cdb_t;

    localparam eu_operand_t OP_ZERO = '{default: 1'b0};
endpackage

module mult_rs
    import mult_rs_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PREG_BITS = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     late_flush,
    input  logic                     dispatch_valid,
    output logic                     dispatch_ready,
    input  eu_operand_t              dispatch_in,
    input  logic [PREG_BITS-1:0]     dispatch_prs1_s,
    input  logic [PREG_BITS-1:0]     dispatch_prs2_s,
    input  logic                     dispatch_rs1_rdy,
    input  logic                     dispatch_rs2_rdy,
    input  logic                     cdb_done,
    input  cdb_t                     cdb_in,
    input  logic                     mult_ready,
    output logic                     mult_start,
    output eu_operand_t              mult_in,
    input  logic                     bra_done,
    input  logic                     bra_mispredict,
    input  logic [EBR_MASK_SIZE-1:0] bra_id
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    eu_operand_t              op_r     [DEPTH];
    logic [PREG_BITS-1:0]     s1_r     [DEPTH];
    logic [PREG_BITS-1:0]     s2_r     [DEPTH];
    logic [DEPTH-1:0]         r1_r, r2_r;
    logic [CNT_W-1:0]         count_r;

    eu_operand_t              upd_op_s [DEPTH];
    eu_operand_t              nxt_op_s [DEPTH];
    logic [PREG_BITS-1:0]     nxt_s1_s [DEPTH];
    logic [PREG_BITS-1:0]     nxt_s2_s [DEPTH];
    logic [DEPTH-1:0]         nxt_r1_s, nxt_r2_s, upd_r1_s, upd_r2_s;
    logic [DEPTH-1:0]         vld_s, wake1_s, wake2_s, squash_s, elig_s, keep_s;
    logic [CNT_W-1:0]         nxt_count_s, pos_s;
    logic [IDX_W-1:0]         cand_s;
    logic                     cand_found_s, issue_s, accept_s;
    logic                     cdb_live_s, mispredict_s, d_wake1_s, d_wake2_s;
    logic [PREG_BITS-1:0]     cdb_tag_s;
    logic [EBR_MASK_SIZE-1:0] clr_mask_s;
    eu_operand_t              disp_op_s;

    // Per-entry wakeup, mask resolve, squash detection and issue eligibility.
    always_comb begin
        cdb_tag_s    = PREG_BITS'(cdb_in.prd_s);
        cdb_live_s   = cdb_done && (cdb_tag_s != {PREG_BITS{1'b0}});
        mispredict_s = bra_done && bra_mispredict;
        clr_mask_s   = (bra_done && !bra_mispredict) ? bra_id : {EBR_MASK_SIZE{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            vld_s[i]   = CNT_W'(i) < count_r;
            wake1_s[i] = cdb_live_s && !r1_r[i] && (s1_r[i] == cdb_tag_s);
            wake2_s[i] = cdb_live_s && !r2_r[i] && (s2_r[i] == cdb_tag_s);
            upd_op_s[i]          = op_r[i];
            upd_op_s[i].prs1_v   = wake1_s[i] ? cdb_in.prd_v : op_r[i].prs1_v;
            upd_op_s[i].prs2_v   = wake2_s[i] ? cdb_in.prd_v : op_r[i].prs2_v;
            upd_op_s[i].ebr_mask = op_r[i].ebr_mask & ~clr_mask_s;
            upd_r1_s[i] = r1_r[i] | wake1_s[i];
            upd_r2_s[i] = r2_r[i] | wake2_s[i];
            squash_s[i] = vld_s[i] && mispredict_s &&
                          ((op_r[i].ebr_mask & bra_id) != {EBR_MASK_SIZE{1'b0}});
`ifdef MULT_RS_WAKEUP_BYPASS_EN
            elig_s[i] = vld_s[i] && upd_r1_s[i] && upd_r2_s[i];
`else
            elig_s[i] = vld_s[i] && r1_r[i] && r2_r[i];
`endif
        end
    end

    // Oldest-ready select and issue outputs; a squashed candidate blocks issue this cycle.
    always_comb begin
        cand_s       = {IDX_W{1'b0}};
        cand_found_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cand_s       = (!cand_found_s && elig_s[i]) ? IDX_W'(i) : cand_s;
            cand_found_s = cand_found_s | elig_s[i];
        end
        issue_s        = cand_found_s && !squash_s[cand_s] && mult_ready && !late_flush;
        mult_start     = issue_s;
        mult_in        = upd_op_s[cand_s];
        mult_in.valid  = issue_s && upd_op_s[cand_s].valid;
        dispatch_ready = count_r < CNT_W'(DEPTH);
    end

    // Compaction of surviving entries followed by the dispatch write at the new tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt_op_s[i] = OP_ZERO;
            nxt_s1_s[i] = {PREG_BITS{1'b0}};
            nxt_s2_s[i] = {PREG_BITS{1'b0}};
        end
        nxt_r1_s = {DEPTH{1'b0}};
        nxt_r2_s = {DEPTH{1'b0}};
        pos_s    = {CNT_W{1'b0}};
        // Dropped entries land at the current tail and are overwritten by the next survivor.
        for (int i = 0; i < DEPTH; i++) begin
            keep_s[i] = vld_s[i] && !squash_s[i] && !(issue_s && (cand_s == IDX_W'(i)));
            nxt_op_s[IDX_W'(pos_s)] = upd_op_s[i];
            nxt_s1_s[IDX_W'(pos_s)] = s1_r[i];
            nxt_s2_s[IDX_W'(pos_s)] = s2_r[i];
            nxt_r1_s[IDX_W'(pos_s)] = upd_r1_s[i];
            nxt_r2_s[IDX_W'(pos_s)] = upd_r2_s[i];
            pos_s = pos_s + CNT_W'(keep_s[i]);
        end
        d_wake1_s = cdb_live_s && !dispatch_rs1_rdy && (dispatch_prs1_s == cdb_tag_s);
        d_wake2_s = cdb_live_s && !dispatch_rs2_rdy && (dispatch_prs2_s == cdb_tag_s);
        disp_op_s          = dispatch_in;
        disp_op_s.prs1_v   = d_wake1_s ? cdb_in.prd_v : dispatch_in.prs1_v;
        disp_op_s.prs2_v   = d_wake2_s ? cdb_in.prd_v : dispatch_in.prs2_v;
        disp_op_s.ebr_mask = dispatch_in.ebr_mask & ~clr_mask_s;
        accept_s = dispatch_valid && dispatch_ready && !late_flush &&
                   !(mispredict_s && ((dispatch_in.ebr_mask & bra_id) != {EBR_MASK_SIZE{1'b0}}));
        if (accept_s) begin
            nxt_op_s[IDX_W'(pos_s)] = disp_op_s;
            nxt_s1_s[IDX_W'(pos_s)] = dispatch_prs1_s;
            nxt_s2_s[IDX_W'(pos_s)] = dispatch_prs2_s;
            nxt_r1_s[IDX_W'(pos_s)] = dispatch_rs1_rdy | d_wake1_s;
            nxt_r2_s[IDX_W'(pos_s)] = dispatch_rs2_rdy | d_wake2_s;
            nxt_count_s = pos_s + CNT_W'(1);
        end else begin
            nxt_count_s = pos_s;
        end
    end

    // Entry storage and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
            r1_r    <= {DEPTH{1'b0}};
            r2_r    <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                op_r[i] <= OP_ZERO;
                s1_r[i] <= {PREG_BITS{1'b0}};
                s2_r[i] <= {PREG_BITS{1'b0}};
            end
        end else if (late_flush) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= nxt_count_s;
            op_r    <= nxt_op_s;
            s1_r    <= nxt_s1_s;
            s2_r    <= nxt_s2_s;
            r1_r    <= nxt_r1_s;
            r2_r    <= nxt_r2_s;
        end
    end
endmodule

// File: tb/tb_mult_rs.sv
// Directed bench for mult_rs: scoreboard of expected issues plus per-cycle timing checks.
module tb_mult_rs;
    import mult_rs_pkg::*;

    localparam int PREG_BITS = 6;
`ifdef MULT_RS_WAKEUP_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct packed {
        logic [ROB_BITS-1:0]      rob;
        logic [31:0]              v1;
        logic [31:0]              v2;
        logic [EBR_MASK_SIZE-1:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst, late_flush, dispatch_valid, dispatch_ready;
    eu_operand_t dispatch_in, mult_in;
    logic [PREG_BITS-1:0] dispatch_prs1_s, dispatch_prs2_s;
    logic dispatch_rs1_rdy, dispatch_rs2_rdy, cdb_done, mult_ready, mult_start;
    cdb_t cdb_in;
    logic bra_done, bra_mispredict;
    logic [EBR_MASK_SIZE-1:0] bra_id;

    exp_t exp_q[$];
    exp_t mon_obs, mon_want;
    int checks = 0;
    int errors = 0;

    mult_rs #(.DEPTH(4), .PREG_BITS(PREG_BITS)) dut (
        .clk(clk), .rst(rst), .late_flush(late_flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_in(dispatch_in), .dispatch_prs1_s(dispatch_prs1_s),
        .dispatch_prs2_s(dispatch_prs2_s), .dispatch_rs1_rdy(dispatch_rs1_rdy),
        .dispatch_rs2_rdy(dispatch_rs2_rdy), .cdb_done(cdb_done), .cdb_in(cdb_in),
        .mult_ready(mult_ready), .mult_start(mult_start), .mult_in(mult_in),
        .bra_done(bra_done), .bra_mispredict(bra_mispredict), .bra_id(bra_id)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int rob, input logic [31:0] v1, input logic [31:0] v2,
                                input logic [EBR_MASK_SIZE-1:0] mask);
        exp_t e;
        e.rob  = ROB_BITS'(rob);
        e.v1   = v1;
        e.v2   = v2;
        e.mask = mask;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic idle();
        dispatch_valid   = 1'b0;
        dispatch_in      = OP_ZERO;
        dispatch_prs1_s  = 6'd0;
        dispatch_prs2_s  = 6'd0;
        dispatch_rs1_rdy = 1'b0;
        dispatch_rs2_rdy = 1'b0;
        cdb_done         = 1'b0;
        cdb_in           = '{default: 1'b0};
        bra_done         = 1'b0;
        bra_mispredict   = 1'b0;
        bra_id           = 4'b0000;
        late_flush       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic disp(input int rob, input logic [5:0] s1, input logic rdy1, input logic [31:0] v1,
                        input logic [5:0] s2, input logic rdy2, input logic [31:0] v2,
                        input logic [EBR_MASK_SIZE-1:0] mask);
        dispatch_valid        = 1'b1;
        dispatch_in           = OP_ZERO;
        dispatch_in.valid     = 1'b1;
        dispatch_in.inst      = 32'h02B50533;
        dispatch_in.rob_id    = ROB_BITS'(rob);
        dispatch_in.prd_s     = PREG_W'(rob + 20);
        dispatch_in.lrd_s     = 5'd10;
        dispatch_in.pc        = 32'h1000 + 32'(rob * 4);
        dispatch_in.prs1_v    = v1;
        dispatch_in.prs2_v    = v2;
        dispatch_in.ebr_mask  = mask;
        dispatch_prs1_s       = s1;
        dispatch_prs2_s       = s2;
        dispatch_rs1_rdy      = rdy1;
        dispatch_rs2_rdy      = rdy2;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] v);
        cdb_done     = 1'b1;
        cdb_in.prd_s = tag;
        cdb_in.prd_v = v;
    endtask

    // Scoreboard: every issue must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mult_start === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL issue_unexpected: got rob %0d, expected no issue", mult_in.rob_id);
            end
            if (exp_q.size() != 0) begin
                mon_want = exp_q.pop_front();
                mon_obs  = {mult_in.rob_id, mult_in.prs1_v, mult_in.prs2_v, mult_in.ebr_mask};
                checks++;
                assert (mon_obs === mon_want) else begin
                    errors++;
                    $error("FAIL issue_data: got %h expected %h", mon_obs, mon_want);
                end
                checks++;
                assert (mult_in.valid === 1'b1) else begin
                    errors++;
                    $error("FAIL issue_valid: got %b expected 1", mult_in.valid);
                end
            end
        end
    end

    initial begin
        logic [EBR_MASK_SIZE-1:0] masks [4];
        masks[0] = 4'b0001; masks[1] = 4'b0010; masks[2] = 4'b0001; masks[3] = 4'b0000;
        rst = 1'b1;
        mult_ready = 1'b0;
        idle();
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_dispatch_ready", dispatch_ready, 32'd1);
        chk("rst_mult_start", mult_start, 32'd0);
        chk("rst_mult_in_valid", mult_in.valid, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Both sources ready at dispatch: issue the following cycle.
        mult_ready = 1'b1;
        disp(1, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 32'd6, 4'b0000);
        exp_q.push_back(mk(1, 32'd7, 32'd6, 4'b0000));
        @(negedge clk); chk("t1_no_issue_at_dispatch", mult_start, 32'd0);
        step();
        @(negedge clk); chk("t1_issue_next", mult_start, 32'd1);
        step();
        @(negedge clk); chk("t1_idle_after", mult_start, 32'd0);
        chk("t1_ready_after", dispatch_ready, 32'd1);

        // A waits on tag 5, B is ready and overtakes it.
        step();
        disp(2, 6'd5, 1'b0, 32'd0, 6'd0, 1'b1, 32'd4, 4'b0000);
        @(negedge clk); chk("t2_c1_no_issue", mult_start, 32'd0);
        step();
        disp(3, 6'd0, 1'b1, 32'd9, 6'd0, 1'b1, 32'd2, 4'b0000);
        exp_q.push_back(mk(3, 32'd9, 32'd2, 4'b0000));
        exp_q.push_back(mk(2, 32'd3, 32'd4, 4'b0000));
        @(negedge clk); chk("t2_c2_no_issue", mult_start, 32'd0);
        step();
        @(negedge clk); chk("t2_c3_b_issues", mult_start, 32'd1);
        step();
        cdb(6'd5, 32'd3);
        @(negedge clk); chk("t2_c4_wakeup_cycle", mult_start, 32'(BYP));
        step();
        @(negedge clk); chk("t2_c5_after_wakeup", mult_start, 32'(!BYP));
        step();
        @(negedge clk); chk("t2_c6_idle", mult_start, 32'd0);

        // Fill all four entries with unready ops; a fifth dispatch is ignored.
        mult_ready = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            disp(4 + k, 6'(10 + k), 1'b0, 32'd0, 6'd0, 1'b1, 32'(k + 1), 4'b0000);
            @(negedge clk); chk("t3_fill_ready", dispatch_ready, 32'd1);
            step();
        end
        disp(8, 6'd0, 1'b1, 32'h88, 6'd0, 1'b1, 32'h99, 4'b0000);
        @(negedge clk); chk("t3_full_not_ready", dispatch_ready, 32'd0);
        step();
        cdb(6'd11, 32'h55);
        exp_q.push_back(mk(5, 32'h55, 32'd2, 4'b0000));
        @(negedge clk); chk("t3_wake_no_issue", mult_start, 32'd0);
        step();
        mult_ready = 1'b1;
        disp(8, 6'd0, 1'b1, 32'h88, 6'd0, 1'b1, 32'h99, 4'b0000);
        @(negedge clk); chk("t3_issue", mult_start, 32'd1);
        chk("t3_full_during_issue", dispatch_ready, 32'd0);
        step();
        mult_ready = 1'b0;
        @(negedge clk); chk("t3_ready_after_issue", dispatch_ready, 32'd1);
        step();

        // Wake the three survivors, then flush while they are issuable.
        cdb(6'd10, 32'hA0); step();
        cdb(6'd12, 32'hA2); step();
        cdb(6'd13, 32'hA3); step();
        mult_ready = 1'b1;
        late_flush = 1'b1;
        @(negedge clk); chk("t6_flush_blocks_issue", mult_start, 32'd0);
        step();
        @(negedge clk); chk("t6_empty_after_flush", mult_start, 32'd0);
        chk("t6_ready_after_flush", dispatch_ready, 32'd1);

        // Masks 0001,0010,0001,0000 then mispredict on 0001.
        mult_ready = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            disp(9 + k, 6'd0, 1'b1, 32'h100 + 32'(k), 6'd0, 1'b1, 32'(k), masks[k]);
            step();
        end
        bra_done = 1'b1; bra_mispredict = 1'b1; bra_id = 4'b0001;
        @(negedge clk); chk("t4_full_before_squash", dispatch_ready, 32'd0);
        step();
        disp(13, 6'd0, 1'b1, 32'h113, 6'd0, 1'b1, 32'd13, 4'b0010);
        @(negedge clk); chk("t4_two_left", dispatch_ready, 32'd1);
        step();

        // Correct resolve of 0010 while the oldest survivor issues.
        mult_ready = 1'b1;
        bra_done = 1'b1; bra_mispredict = 1'b0; bra_id = 4'b0010;
        exp_q.push_back(mk(10, 32'h101, 32'd1, 4'b0000));
        @(negedge clk); chk("t5_issue_with_resolve", mult_start, 32'd1);
        step();
        // Mispredict on the already-resolved bit must not drop anything.
        mult_ready = 1'b0;
        bra_done = 1'b1; bra_mispredict = 1'b1; bra_id = 4'b0010;
        exp_q.push_back(mk(12, 32'h103, 32'd3, 4'b0000));
        exp_q.push_back(mk(13, 32'h113, 32'd13, 4'b0000));
        @(negedge clk); chk("t5_hold", mult_start, 32'd0);
        step();
        mult_ready = 1'b1;
        @(negedge clk); chk("t5_issue_rob12", mult_start, 32'd1);
        step();
        @(negedge clk); chk("t5_issue_rob13", mult_start, 32'd1);
        step();
        @(negedge clk); chk("t5_drained", mult_start, 32'd0);
        chk("t5_ready_end", dispatch_ready, 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
